// File: rtl/symbol_unpack_pkg.sv
// Shared definitions for the symbol unpacker / repeater.
//   BPS_*          : encodings of the bits-per-symbol select (0->1, 1->2, 2->4, 3->8)
//   bps_from_sel() : bit count for a select value
//   spw()          : symbols contained in one input word for a select value
//   state_t        : controller states
package symbol_unpack_pkg;

   localparam logic [1:0] BPS_1 = 2'd0;
   localparam logic [1:0] BPS_2 = 2'd1;
   localparam logic [1:0] BPS_4 = 2'd2;
   localparam logic [1:0] BPS_8 = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   function automatic int unsigned bps_from_sel(input logic [1:0] sel);
      return 32'd1 << sel;
   endfunction

   function automatic int unsigned spw(input int unsigned in_width, input logic [1:0] sel);
      return in_width >> sel;
   endfunction

endpackage

// File: rtl/symbol_slice_shift.sv
// Word shift register with symbol extraction.
//   clk, reset_n : clock, asynchronous active-low reset (clears the register)
//   load         : capture load_data (has priority over shift)
//   load_data    : packed input word
//   shift        : advance by one symbol toward the slice end
//   bps          : bits-per-symbol select of the word in flight
//   msb_first    : 1 = symbols taken from the top of the word, 0 = from bit 0
//   sym          : current symbol, right-aligned, bits above bps forced to 0
module symbol_slice_shift
   import symbol_unpack_pkg::*;
#(
   parameter int IN_WIDTH = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load,
   input  logic [IN_WIDTH-1:0] load_data,
   input  logic                shift,
   input  logic [1:0]          bps,
   input  logic                msb_first,
   output logic [7:0]          sym
);

   logic [IN_WIDTH-1:0] sh_q, sh_d;
   logic [3:0]          step;
   logic [7:0]          top8;

   assign step = 4'(bps_from_sel(bps));
   assign top8 = sh_q[IN_WIDTH-1 -: 8];

   // Consumed bits are shifted out, so a fully emitted word leaves the
   // register at zero and the output reads 0 while idle.
   always_comb begin
      sh_d = sh_q;
      if (load) begin
         sh_d = load_data;
      end else if (shift) begin
         sh_d = msb_first ? (sh_q << step) : (sh_q >> step);
      end
   end

   always_comb begin
      if (msb_first) begin
         sym = top8 >> (4'd8 - step);
      end else begin
         sym = sh_q[7:0] & (8'hFF >> (4'd8 - step));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

endmodule

// File: rtl/symbol_unpack_repeat.sv
// Symbol unpacker and repeater: slices packed words into 1/2/4/8-bit symbols
// and emits each symbol a programmable number of times.
//   clk, reset_n          : clock, asynchronous active-low reset
//   cfg_bps_sel           : bits per symbol select (0->1, 1->2, 2->4, 3->8)
//   cfg_repeat            : emissions per symbol (0 -> 1, >MAX_REPEAT -> MAX_REPEAT)
//   cfg_msb_first         : slice order within the word
//   in_tdata/in_tlast     : packed word and packet-end flag
//   in_tvalid/in_tready   : input handshake
//   out_tdata/out_tlast   : zero-extended symbol and packet-end flag
//   out_tvalid/out_tready : output handshake
//   busy                  : a word is held
module symbol_unpack_repeat
   import symbol_unpack_pkg::*;
#(
   parameter  int IN_WIDTH   = 32,
   parameter  int MAX_REPEAT = 16,
   parameter  int OUT_WIDTH  = 32,
   localparam int REP_W      = $clog2(MAX_REPEAT + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           cfg_bps_sel,
   input  logic [REP_W-1:0]     cfg_repeat,
   input  logic                 cfg_msb_first,
   input  logic [IN_WIDTH-1:0]  in_tdata,
   input  logic                 in_tlast,
   input  logic                 in_tvalid,
   output logic                 in_tready,
   output logic [OUT_WIDTH-1:0] out_tdata,
   output logic                 out_tlast,
   output logic                 out_tvalid,
   input  logic                 out_tready,
   output logic                 busy
);

   localparam int               IDX_W   = $clog2(IN_WIDTH);
   localparam logic [REP_W-1:0] MAX_REP = REP_W'(MAX_REPEAT);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   sym_idx_q, sym_idx_d;
   logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic [1:0]         bps_q, bps_d;
   logic               msb_first_q, msb_first_d;
   logic               tlast_q, tlast_d;

   logic [REP_W-1:0]   rep_clamped;
   logic               last_sym, last_rep, last_emit;
   logic               in_hs, out_hs, shift;
   logic [7:0]         sym;

   always_comb begin
      if (cfg_repeat == '0) begin
         rep_clamped = REP_W'(1);
      end else if (cfg_repeat > MAX_REP) begin
         rep_clamped = MAX_REP;
      end else begin
         rep_clamped = cfg_repeat;
      end
   end

   assign busy      = (state_q == ST_EMIT);
   assign last_sym  = (sym_idx_q == IDX_W'(spw(IN_WIDTH, bps_q) - 1));
   assign last_rep  = (rep_cnt_q == (rep_q - REP_W'(1)));
   assign last_emit = busy && last_sym && last_rep;

   // Ready is held low while reset is asserted; otherwise a new word may be
   // taken in the same cycle the final emission of the current word leaves.
   assign in_tready = reset_n && (!busy || (last_emit && out_tready));
   assign in_hs     = in_tvalid && in_tready;
   assign out_hs    = busy && out_tready;
   assign shift     = out_hs && last_rep;

   assign out_tvalid = busy;
   assign out_tlast  = last_emit && tlast_q;
   assign out_tdata  = OUT_WIDTH'(sym);

   always_comb begin
      state_d     = state_q;
      sym_idx_d   = sym_idx_q;
      rep_cnt_d   = rep_cnt_q;
      rep_d       = rep_q;
      bps_d       = bps_q;
      msb_first_d = msb_first_q;
      tlast_d     = tlast_q;
      if (in_hs) begin
         state_d     = ST_EMIT;
         sym_idx_d   = '0;
         rep_cnt_d   = '0;
         rep_d       = rep_clamped;
         bps_d       = cfg_bps_sel;
         msb_first_d = cfg_msb_first;
         tlast_d     = in_tlast;
      end else if (out_hs) begin
         if (last_emit) begin
            state_d   = ST_IDLE;
            sym_idx_d = '0;
            rep_cnt_d = '0;
         end else if (!last_rep) begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
         end else begin
            rep_cnt_d = '0;
            sym_idx_d = sym_idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         sym_idx_q   <= '0;
         rep_cnt_q   <= '0;
         rep_q       <= '0;
         bps_q       <= BPS_1;
         msb_first_q <= 1'b0;
         tlast_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sym_idx_q   <= sym_idx_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_q       <= rep_d;
         bps_q       <= bps_d;
         msb_first_q <= msb_first_d;
         tlast_q     <= tlast_d;
      end
   end

   symbol_slice_shift #(
      .IN_WIDTH (IN_WIDTH)
   ) u_slice (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (in_hs),
      .load_data (in_tdata),
      .shift     (shift),
      .bps       (bps_q),
      .msb_first (msb_first_q),
      .sym       (sym)
   );

endmodule

// File: doc/symbol_unpack_repeat.md
# symbol_unpack_repeat

Parametrised symbol unpacker and repeater for the transmit modulator chain. It accepts packed payload words and slices each word into 1-, 2-, 4- or 8-bit symbols, selectable at runtime. Each symbol is emitted a programmable number of times, with MSB-first or LSB-first ordering. It sits between the rate-change stage and the symbol mapper, and replaces the fixed 2-bit converter plus fixed-N repeater pair with a single block that preserves packet boundaries.

## Interface
- IN_WIDTH, 32, input word width; must be a multiple of 8
- MAX_REPEAT, 16, largest repeat count; REP_W = $clog2(MAX_REPEAT+1)
- OUT_WIDTH, 32, output word width; must be ≥ 8
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_bps_sel  in  2  bits per symbol: 0→1, 1→2, 2→4, 3→8
- cfg_repeat  in  REP_W  emissions per symbol; 0 is treated as 1; values above MAX_REPEAT saturate to MAX_REPEAT
- cfg_msb_first  in  1  1: slice from bit IN_WIDTH-1 downward; 0: slice from bit 0 upward
- in_tdata  in  IN_WIDTH  packed symbols
- in_tlast  in  1  last word of packet
- in_tvalid / in_tready  in / out  1  input handshake
- out_tdata  out  OUT_WIDTH  symbol, zero-extended in the low bits
- out_tlast  out  1  final emission of the final symbol of an in_tlast word
- out_tvalid / out_tready  out / in  1  output handshake
- busy  out  1  high while a word is held

## Operation
- Two states, IDLE and EMIT.
- On an input handshake:
  - load the word into the shift register;
  - latch bps, the clamped repeat count, msb_first and in_tlast;
  - clear sym_idx and rep_cnt;
  - go to EMIT.
- Config is sampled only at an input handshake. Changes during EMIT have no effect on the word in flight.
- Symbols per word: SPW = IN_WIDTH / bps, giving 32, 16, 8 or 4 at the default width.
- Each output handshake in EMIT:
  - if rep_cnt < rep−1, increment rep_cnt and keep the same symbol;
  - otherwise clear rep_cnt, shift the register by bps toward the slice end and increment sym_idx.
- Last emission condition: sym_idx = SPW−1 and rep_cnt = rep−1. When its handshake completes, go to IDLE. If a new input handshake occurs in the same cycle, reload and stay in EMIT.
- out_tlast = latched tlast AND last emission.
- in_tready = !busy OR (last emission AND out_tready). This is combinational and gives zero-bubble, back-to-back words.
- out_tdata is the current slice masked to bps bits; all bits above are 0.
- Total emissions per word: SPW × rep, for example 16 × 4 = 64 for QPSK with repeat 4.

## Timing
- Reset values: out_tvalid=0, out_tlast=0, out_tdata=0, busy=0, state=IDLE, all counters 0.
- in_tready=0 while reset_n is low, and 1 in the first cycle after release.
- Latency: a word accepted at edge t produces its first symbol with out_tvalid=1 after edge t (registered). Sustained throughput is 1 symbol per cycle.
- While out_tvalid=1 and out_tready=0, out_tdata and out_tlast stay stable and the counters hold.
- out_tvalid never drops without a handshake, except on reset.
- Reset mid-word discards the held word and all partial counts immediately. No output beat follows until a new input handshake.
- cfg_bps_sel changes across words take effect at the next word boundary, with no gap cycles.

## Structure
- Package symbol_unpack_pkg holds:
  - the bps encoding localparams BPS_1/2/4/8;
  - a function bps_from_sel returning the bit count;
  - a function spw returning symbols per word;
  - state enum constants ST_IDLE and ST_EMIT.
- Sub-module symbol_slice_shift holds the shift register, masking and direction select. Its inputs are load, shift, bps and msb_first; its output is the current symbol.
- The top level holds the FSM, the counters and the handshake logic.

## Test plan
- bps=2, rep=1, msb_first=1, in 0xE4E4E4E4 → 16 beats: 3,2,1,0 repeated ×4; out_tlast only on beat 16 if in_tlast=1.
- bps=2, rep=4, msb_first=0, in 0x0000001B → 64 beats: 3,3,3,3,2,2,2,2,1,1,1,1,0,0,0,0, then 48 zeros.
- bps=8, rep=0 (treated as 1), two back-to-back words 0x11223344 and 0xAABBCCDD, out_tready tied high → 8 consecutive beats 0x11,0x22,0x33,0x44,0xAA,0xBB,0xCC,0xDD with no idle cycle.
- bps=1, rep=2, random out_tready stalls → 64 beats match the bit sequence doubled; out_tdata is stable during every stall; bps change mid-word has no effect.
- Reset asserted during beat 5 of a 4-bit word → out_tvalid=0 immediately and in_tready=1 after release; the next word 0x89ABCDEF emits 8,9,A,B,C,D,E,F.
- cfg_repeat=31 with MAX_REPEAT=16, bps=4 → each symbol emitted exactly 16 times, 128 beats total.
